audio_nco_clkgen: RTL and testbench
===================================

Name: audio_nco_clkgen

Overview:
Parametrised, fully digital successor to the fixed two-output audio PLL wrapper. It generates NUM_CLKS audio-rate clock enables plus square-wave clocks (MCLK, BCLK, LRCLK class) from the board reference clock. Each channel uses a phase-accumulator NCO, so output frequencies are runtime-programmable. Ratio changes are glitch-free, and a lock indicator covers settling. It sits between the reference clock pin and the codec serial interface; downstream logic runs on refclk and qualifies with clk_en.

Parameters:
NUM_CLKS, 2, number of independent NCO channels (1..8)
ACC_W, 32, accumulator width; f_out = f_ref * inc / 2^ACC_W
DEFAULT_INC, {NUM_CLKS{ACC_W'0}}, packed per-channel reset increment; channel i at bits [i*ACC_W +: ACC_W]
LOCK_CYCLES, 1024, refclk cycles of stable configuration before locked asserts (>=1)

Ports:
refclk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
chan_en  in  NUM_CLKS  per-channel run enable
cfg_valid  in  1  increment update request
cfg_ready  out  1  update slot free
cfg_chan  in  $clog2(NUM_CLKS) (min 1)  target channel
cfg_inc  in  ACC_W  new increment
clk_en  out  NUM_CLKS  one-cycle pulse per output period (rising-edge equivalent)
clk_out  out  NUM_CLKS  square wave = registered accumulator MSB
locked  out  1  all enabled channels stable for LOCK_CYCLES

Behaviour:
- Reset (async assert, sync release):
  - acc = 0, inc = DEFAULT_INC, clk_en = 0, clk_out = 0, locked = 0, cfg_ready = 0.
  - cfg_ready rises on the first refclk edge after rst deasserts.
- NCO per channel, when chan_en[i] = 1:
  - Every cycle: {carry, acc_next} = acc + inc (ACC_W+1 bits); acc <= acc_next, modulo 2^ACC_W.
  - clk_en[i] <= carry, so it is high the cycle after the wrapping add (1-cycle latency).
  - clk_out[i] <= acc_next[ACC_W-1].
- Channel disabled (chan_en[i] = 0): acc held at 0, clk_en[i] = 0, clk_out[i] = 0 from the next edge. Re-enable restarts from phase 0.
- inc = 0: channel is stopped. acc frozen, no clk_en.
- Config handshake:
  - Transfer when cfg_valid && cfg_ready. The single pending slot captures {cfg_chan, cfg_inc}; cfg_ready <= 0.
  - cfg_chan >= NUM_CLKS: the request is accepted and discarded. cfg_ready returns next cycle, no lock effect.
- Pending apply is glitch-free:
  - Applied in the cycle the target channel's add produces carry, and only for additions from the next cycle on.
  - The wrapping add itself uses the old inc; the next add uses the new inc.
  - Applied immediately (next edge) if the target channel is disabled or its current inc = 0.
  - On apply: pending cleared; cfg_ready <= 1 the following cycle; lock FSM forced to SETTLE.
- Lock FSM, states SETTLE and LOCKED (reset: SETTLE, cnt = 0):
  - SETTLE: cnt increments each cycle. At cnt == LOCK_CYCLES-1 -> LOCKED, locked <= 1.
  - LOCKED: a pending apply or any chan_en edge -> SETTLE, cnt = 0, locked <= 0 next edge.
  - Accepting a request alone does not drop locked.
- Simultaneous events:
  - Apply and a chan_en change in the same cycle: a single restart of cnt.
  - Carry and apply in the same cycle: clk_en is still asserted for that carry.
- Reset mid-update: pending is discarded and inc reverts to DEFAULT_INC.

Decomposition:
- Package audio_clk_pkg holds: ACC_W default, lock_state_e {SETTLE, LOCKED}, cfg_req_t struct {chan, inc}, and a helper function inc_for(f_ref_hz, f_out_hz, acc_w) for computing default increments.
- Sub-module audio_nco_chan holds one accumulator, inc register, carry/clk_en/clk_out logic, and the apply-at-wrap gate. It is instantiated NUM_CLKS times by a generate loop.
- The top level holds the pending slot, handshake and lock FSM.

Test Plan:
- Bench parameters: ACC_W=8, DEFAULT_INC={64 (ch1), 32 (ch0)}, LOCK_CYCLES=16, chan_en=2'b11.
- Reset release -> ch1 clk_en every 4 cycles, first at cycle 4. ch0 clk_en every 8 cycles. clk_out[1] is 2 high / 2 low. locked rises 16 cycles after release.
- Write ch0 inc=128 at mid-period -> cfg_ready drops for the transfer. Old 8-cycle period completes, then period is 2. locked falls the cycle after apply and returns 16 cycles later.
- Two back-to-back requests -> second held (cfg_ready=0) until the first applies. Second accepted the cycle after cfg_ready returns. No clk_en glitch or missed pulse.
- ch0 inc=3 -> exactly 9 clk_en pulses in 768 cycles. Spacing is only 85 or 86.
- Deassert chan_en[1] -> clk_out[1]=0, no pulses, locked drops. Reassert -> first pulse 4 cycles later, locked after 16.
- Assert rst mid-pending with cfg_chan=5 (invalid) previously sent -> all outputs take reset values asynchronously and incs return to 64/32. Invalid request causes no lock drop.

Source files
------------

// File: rtl/audio_clk_pkg.sv
// Shared types and helpers for the audio NCO clock generator.
// Used by the NCO channel and by the top level.
package audio_clk_pkg;

   localparam int ACC_W_DEF  = 32;
   localparam int CHAN_W_MAX = 3;

   typedef enum logic [0:0] {
      SETTLE = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

   typedef struct packed {
      logic [CHAN_W_MAX-1:0] chan;
      logic [ACC_W_DEF-1:0]  inc;
   } cfg_req_t;

   // Rounded increment for f_out from f_ref; (f_out << acc_w) must fit in 64 bits
   function automatic logic [63:0] inc_for(input logic [63:0] f_ref_hz,
                                           input logic [63:0] f_out_hz,
                                           input int unsigned acc_w);
      logic [63:0] num_v;
      num_v = (f_out_hz << acc_w) + (f_ref_hz >> 1);
      if (f_ref_hz == 64'd0) begin
         return 64'd0;
      end else begin
         return num_v / f_ref_hz;
      end
   endfunction

endpackage

// File: rtl/audio_nco_chan.sv
// One phase-accumulator NCO channel with a pending-increment gate
// that only swaps the increment on the wrapping add.
module audio_nco_chan
   import audio_clk_pkg::*;
#(
   parameter int               ACC_W       = ACC_W_DEF,
   parameter logic [ACC_W-1:0] DEFAULT_INC = {ACC_W{1'b0}}
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             en,
   input  logic             pend_hit,
   input  logic [ACC_W-1:0] pend_inc,
   output logic             apply,
   output logic             clk_en,
   output logic             clk_out
);

   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] inc_r;
   logic [ACC_W:0]   sum_s;
   logic             apply_s;
   logic             clk_en_r;
   logic             clk_out_r;

   // Wrapping add; a stopped or disabled channel takes a new increment at once
   always_comb begin
      sum_s   = {1'b0, acc_r} + {1'b0, inc_r};
      apply_s = pend_hit && (!en || (inc_r == {ACC_W{1'b0}}) || sum_s[ACC_W]);
   end

   // Accumulator, increment register and registered clock outputs
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         acc_r     <= {ACC_W{1'b0}};
         inc_r     <= DEFAULT_INC;
         clk_en_r  <= 1'b0;
         clk_out_r <= 1'b0;
      end else begin
         if (en) begin
            acc_r     <= sum_s[ACC_W-1:0];
            clk_en_r  <= sum_s[ACC_W];
            clk_out_r <= sum_s[ACC_W-1];
         end else begin
            acc_r     <= {ACC_W{1'b0}};
            clk_en_r  <= 1'b0;
            clk_out_r <= 1'b0;
         end
         if (apply_s) begin
            inc_r <= pend_inc;
         end
      end
   end

   assign apply   = apply_s;
   assign clk_en  = clk_en_r;
   assign clk_out = clk_out_r;

endmodule

// File: rtl/audio_nco_clkgen.sv
// Multi-channel audio clock generator: NCO channels, a single-entry
// increment update slot and a lock supervisor covering settling.
module audio_nco_clkgen
   import audio_clk_pkg::*;
#(
   parameter int                         NUM_CLKS    = 2,
   parameter int                         ACC_W       = ACC_W_DEF,
   parameter logic [NUM_CLKS*ACC_W-1:0]  DEFAULT_INC = {(NUM_CLKS*ACC_W){1'b0}},
   parameter int                         LOCK_CYCLES = 1024,
   localparam int                        CHAN_W      = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic [NUM_CLKS-1:0] chan_en,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CHAN_W-1:0]   cfg_chan,
   input  logic [ACC_W-1:0]    cfg_inc,
   output logic [NUM_CLKS-1:0] clk_en,
   output logic [NUM_CLKS-1:0] clk_out,
   output logic                locked
);

   localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   logic [NUM_CLKS-1:0] apply_s;
   logic [NUM_CLKS-1:0] en_prev_r;
   logic                en_prev_vld_r;
   logic                pend_vld_r;
   logic [CHAN_W-1:0]   pend_chan_r;
   logic [ACC_W-1:0]    pend_inc_r;
   logic                cfg_ready_r;
   logic                locked_r;
   logic [CNT_W-1:0]    cnt_r;
   lock_state_e         state_r;
   logic                accept_s;
   logic                chan_ok_s;
   logic                restart_s;

   // Handshake qualifiers and the single lock-restart condition
   always_comb begin
      accept_s  = cfg_valid && cfg_ready_r;
      chan_ok_s = (32'(cfg_chan) < 32'(NUM_CLKS));
      restart_s = (|apply_s) || (en_prev_vld_r && (chan_en != en_prev_r));
   end

   generate
      for (genvar i = 0; i < NUM_CLKS; i++) begin : g_chan
         audio_nco_chan #(
            .ACC_W       (ACC_W),
            .DEFAULT_INC (DEFAULT_INC[i*ACC_W +: ACC_W])
         ) u_chan (
            .refclk   (refclk),
            .rst      (rst),
            .en       (chan_en[i]),
            .pend_hit (pend_vld_r && (pend_chan_r == CHAN_W'(i))),
            .pend_inc (pend_inc_r),
            .apply    (apply_s[i]),
            .clk_en   (clk_en[i]),
            .clk_out  (clk_out[i])
         );
      end
   endgenerate

   // Pending slot: out-of-range channels are accepted but never stored
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         pend_vld_r    <= 1'b0;
         pend_chan_r   <= {CHAN_W{1'b0}};
         pend_inc_r    <= {ACC_W{1'b0}};
         cfg_ready_r   <= 1'b0;
         en_prev_r     <= {NUM_CLKS{1'b0}};
         en_prev_vld_r <= 1'b0;
      end else begin
         if (accept_s) begin
            pend_vld_r  <= chan_ok_s;
            pend_chan_r <= cfg_chan;
            pend_inc_r  <= cfg_inc;
            cfg_ready_r <= 1'b0;
         end else if (pend_vld_r) begin
            if (|apply_s) begin
               pend_vld_r  <= 1'b0;
               cfg_ready_r <= 1'b1;
            end
         end else begin
            cfg_ready_r <= 1'b1;
         end
         en_prev_r     <= chan_en;
         en_prev_vld_r <= 1'b1;
      end
   end

   // Lock supervisor: count stable cycles, restart on apply or enable change
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_r  <= SETTLE;
         cnt_r    <= {CNT_W{1'b0}};
         locked_r <= 1'b0;
      end else if (restart_s) begin
         state_r  <= SETTLE;
         cnt_r    <= {CNT_W{1'b0}};
         locked_r <= 1'b0;
      end else begin
         case (state_r)
            SETTLE: begin
               if (cnt_r == CNT_LAST) begin
                  state_r  <= LOCKED;
                  locked_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            LOCKED: begin
               locked_r <= 1'b1;
            end
            default: begin
               state_r  <= SETTLE;
               cnt_r    <= {CNT_W{1'b0}};
               locked_r <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready = cfg_ready_r;
   assign locked    = locked_r;

endmodule

// File: tb/tb_audio_nco_clkgen.sv
// Directed bench for audio_nco_clkgen: a two-channel instance with an
// 8-bit accumulator, plus a five-channel instance for out-of-range requests.
module tb_audio_nco_clkgen;
   import audio_clk_pkg::*;

   localparam logic [15:0] DEF_INC = {8'(inc_for(64'd1024, 64'd256, 8)),
                                      8'(inc_for(64'd1024, 64'd128, 8))};

   logic       refclk = 1'b0;
   logic       rst    = 1'b1;
   logic [1:0] chan_en = 2'b11;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [0:0] cfg_chan = 1'b0;
   logic [7:0] cfg_inc = 8'd0;
   logic [1:0] clk_en;
   logic [1:0] clk_out;
   logic       locked;

   logic [4:0] chan_en5 = 5'b11111;
   logic       cfg_valid5 = 1'b0;
   logic       cfg_ready5;
   logic [2:0] cfg_chan5 = 3'd0;
   logic [7:0] cfg_inc5 = 8'd0;
   logic [4:0] clk_en5;
   logic [4:0] clk_out5;
   logic       locked5;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 refclk = ~refclk;

   audio_nco_clkgen #(
      .NUM_CLKS(2), .ACC_W(8), .DEFAULT_INC(DEF_INC), .LOCK_CYCLES(16)
   ) u_dut (
      .refclk(refclk), .rst(rst), .chan_en(chan_en), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_chan(cfg_chan), .cfg_inc(cfg_inc),
      .clk_en(clk_en), .clk_out(clk_out), .locked(locked)
   );

   audio_nco_clkgen #(
      .NUM_CLKS(5), .ACC_W(8), .DEFAULT_INC({5{8'd32}}), .LOCK_CYCLES(4)
   ) u_dut5 (
      .refclk(refclk), .rst(rst), .chan_en(chan_en5), .cfg_valid(cfg_valid5),
      .cfg_ready(cfg_ready5), .cfg_chan(cfg_chan5), .cfg_inc(cfg_inc5),
      .clk_en(clk_en5), .clk_out(clk_out5), .locked(locked5)
   );

   task automatic step();
      @(posedge refclk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge refclk);
      #1;
      checks++;
      if ({clk_en, clk_out, locked, cfg_ready} !== 6'b0) begin
         errors++;
         $display("FAIL reset_main: got %b expected %b", {clk_en, clk_out, locked, cfg_ready}, 6'b0);
      end
      checks++;
      if ({clk_en5, clk_out5, locked5, cfg_ready5} !== 12'b0) begin
         errors++;
         $display("FAIL reset_dut5: got %b expected %b", {clk_en5, clk_out5, locked5, cfg_ready5}, 12'b0);
      end
      rst = 1'b0;
      cyc = 0;
   endtask

   // ch1 inc 64, ch0 inc 32, lock after 16 edges; dut5 all inc 32, lock after 4
   task automatic test_default_rates(input int n);
      logic [5:0] exp_v;
      logic [6:0] exp5_v;
      for (int k = 1; k <= n; k++) begin
         step();
         exp_v[5] = (k % 4 == 0);
         exp_v[4] = (k % 8 == 0);
         exp_v[3] = (((k * 64) % 256) >= 128);
         exp_v[2] = (((k * 32) % 256) >= 128);
         exp_v[1] = (k >= 16);
         exp_v[0] = 1'b1;
         checks++;
         if ({clk_en, clk_out, locked, cfg_ready} !== exp_v) begin
            errors++;
            $display("FAIL default_rates cyc=%0d: got %b expected %b", cyc,
                     {clk_en, clk_out, locked, cfg_ready}, exp_v);
         end
         exp5_v = {((k % 8 == 0) ? 5'b11111 : 5'b00000), (k >= 4), 1'b1};
         checks++;
         if ({clk_en5, locked5, cfg_ready5} !== exp5_v) begin
            errors++;
            $display("FAIL default_rates5 cyc=%0d: got %b expected %b", cyc,
                     {clk_en5, locked5, cfg_ready5}, exp5_v);
         end
      end
   endtask

   // ch0 inc 32 -> 128 requested at acc=128: old period ends at edge 24
   task automatic test_ratio_change();
      logic [3:0] exp_v;
      cfg_valid = 1'b1;
      cfg_chan  = 1'b0;
      cfg_inc   = 8'd128;
      step();
      cfg_valid = 1'b0;
      checks++;
      if ({cfg_ready, locked} !== 2'b01) begin
         errors++;
         $display("FAIL ratio_accept: got %b expected %b", {cfg_ready, locked}, 2'b01);
      end
      for (int e = 22; e <= 42; e++) begin
         step();
         exp_v[3] = (cyc % 4 == 0);
         exp_v[2] = (cyc == 24) || ((cyc > 24) && (cyc % 2 == 0));
         exp_v[1] = (cyc < 24) || (cyc >= 40);
         exp_v[0] = (cyc >= 24);
         checks++;
         if ({clk_en, locked, cfg_ready} !== exp_v) begin
            errors++;
            $display("FAIL ratio_change cyc=%0d: got %b expected %b", cyc,
                     {clk_en, locked, cfg_ready}, exp_v);
         end
      end
   endtask

   // ch0 -> 64 (applies at edge 44), then ch0 -> 3 held until accepted at 45
   task automatic test_back_to_back();
      logic [3:0] exp_v;
      cfg_valid = 1'b1;
      cfg_chan  = 1'b0;
      cfg_inc   = 8'd64;
      for (int e = 43; e <= 48; e++) begin
         step();
         exp_v[3] = (cyc % 4 == 0);
         exp_v[2] = (cyc == 44) || (cyc == 48);
         exp_v[1] = (cyc == 43);
         exp_v[0] = (cyc == 44) || (cyc == 48);
         checks++;
         if ({clk_en, locked, cfg_ready} !== exp_v) begin
            errors++;
            $display("FAIL back_to_back cyc=%0d: got %b expected %b", cyc,
                     {clk_en, locked, cfg_ready}, exp_v);
         end
         if (cyc == 43) cfg_inc = 8'd3;
         if (cyc == 45) cfg_valid = 1'b0;
      end
   endtask

   // ch0 inc 3 from phase 0: 9 pulses in 768 edges, spacing 85 or 86
   task automatic test_fractional();
      int pulses;
      int last;
      int sp;
      pulses = 0;
      last   = 48;
      for (int e = 49; e <= 816; e++) begin
         step();
         if (clk_en[0]) begin
            pulses++;
            sp = cyc - last;
            checks++;
            if (!((sp == 85) || (sp == 86))) begin
               errors++;
               $display("FAIL frac_spacing cyc=%0d: got %0d expected 85 or 86", cyc, sp);
            end
            last = cyc;
         end
      end
      checks++;
      if (pulses !== 9) begin
         errors++;
         $display("FAIL frac_count: got %0d expected 9", pulses);
      end
      checks++;
      if ({last, locked} !== {816, 1'b1}) begin
         errors++;
         $display("FAIL frac_last: got last=%0d locked=%b expected last=816 locked=1", last, locked);
      end
   endtask

   task automatic test_chan_disable();
      logic [2:0] exp_v;
      chan_en = 2'b01;
      for (int e = 817; e <= 825; e++) begin
         step();
         checks++;
         if ({clk_en[1], clk_out[1], locked} !== 3'b000) begin
            errors++;
            $display("FAIL chan_off cyc=%0d: got %b expected %b", cyc,
                     {clk_en[1], clk_out[1], locked}, 3'b000);
         end
      end
      chan_en = 2'b11;
      for (int e = 826; e <= 845; e++) begin
         step();
         exp_v[2] = ((cyc - 825) % 4 == 0);
         exp_v[1] = ((((cyc - 825) * 64) % 256) >= 128);
         exp_v[0] = (cyc >= 842);
         checks++;
         if ({clk_en[1], clk_out[1], locked} !== exp_v) begin
            errors++;
            $display("FAIL chan_on cyc=%0d: got %b expected %b", cyc,
                     {clk_en[1], clk_out[1], locked}, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid_pending();
      logic [6:0] exp5_v;
      cfg_valid5 = 1'b1;
      cfg_chan5  = 3'd5;
      cfg_inc5   = 8'd200;
      step();
      cfg_valid5 = 1'b0;
      checks++;
      if ({cfg_ready5, locked5} !== 2'b01) begin
         errors++;
         $display("FAIL invalid_accept: got %b expected %b", {cfg_ready5, locked5}, 2'b01);
      end
      for (int e = 847; e <= 856; e++) begin
         step();
         exp5_v = {((cyc % 8 == 0) ? 5'b11111 : 5'b00000), 1'b1, 1'b1};
         checks++;
         if ({clk_en5, locked5, cfg_ready5} !== exp5_v) begin
            errors++;
            $display("FAIL invalid_discard cyc=%0d: got %b expected %b", cyc,
                     {clk_en5, locked5, cfg_ready5}, exp5_v);
         end
      end
      cfg_valid = 1'b1;
      cfg_chan  = 1'b1;
      cfg_inc   = 8'd16;
      step();
      cfg_valid = 1'b0;
      checks++;
      if ({cfg_ready, locked, clk_en[1]} !== 3'b011) begin
         errors++;
         $display("FAIL pend_before_rst: got %b expected %b", {cfg_ready, locked, clk_en[1]}, 3'b011);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({clk_en, clk_out, locked, cfg_ready, clk_en5, clk_out5, locked5, cfg_ready5} !== 18'b0) begin
         errors++;
         $display("FAIL async_rst: got %b expected %b",
                  {clk_en, clk_out, locked, cfg_ready, clk_en5, clk_out5, locked5, cfg_ready5}, 18'b0);
      end
      @(posedge refclk);
      #1;
      checks++;
      if ({clk_en, clk_out, locked, cfg_ready} !== 6'b0) begin
         errors++;
         $display("FAIL held_rst: got %b expected %b", {clk_en, clk_out, locked, cfg_ready}, 6'b0);
      end
      @(posedge refclk);
      #1;
      rst = 1'b0;
      cyc = 0;
      test_default_rates(20);
   endtask

   initial begin
      test_reset();
      test_default_rates(20);
      test_ratio_change();
      test_back_to_back();
      test_fractional();
      test_chan_disable();
      test_reset_mid_pending();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
